// File: rtl/aes_pkg.sv
// AES-128 round helpers shared by the round pipeline, its S-box leaf and its
// bus interface.
//   aes_state_t : 16-byte state, byte 0 in bits [127:120], column-major
//   RCON        : round constants, valid at index 1..10 (other entries 0)
//   sbox/xtime  : byte substitution and GF(2^8) doubling
//   shift_rows, mix_columns, expand_key : whole-state round transforms
package aes_pkg;

   typedef logic [0:15][7:0] aes_state_t;

   localparam logic [3:0] AES_LAST_ROUND = 4'd10;

   localparam logic [0:15][7:0] RCON = {
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
      8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
   };

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] p;
      acc = '0;
      p   = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   // Inverse computed as b^254 (0 maps to 0), followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = b;
      inv = 8'h01;
      for (int unsigned k = 1; k < 8; k++) begin
         sq  = gmul(sq, sq);
         inv = gmul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   // Row r of column c takes the byte of column (c+r) mod 4.
   function automatic aes_state_t shift_rows(input aes_state_t s);
      aes_state_t r;
      for (int unsigned c = 0; c < 4; c++) begin
         for (int unsigned w = 0; w < 4; w++) begin
            r[4'(c * 4 + w)] = s[4'(((c + w) % 4) * 4 + w)];
         end
      end
      return r;
   endfunction

   function automatic aes_state_t mix_columns(input aes_state_t s);
      aes_state_t r;
      logic [7:0] a0, a1, a2, a3;
      logic [3:0] base;
      for (int unsigned c = 0; c < 4; c++) begin
         base = 4'(c * 4);
         a0 = s[base];
         a1 = s[base + 4'd1];
         a2 = s[base + 4'd2];
         a3 = s[base + 4'd3];
         r[base]        = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         r[base + 4'd1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         r[base + 4'd2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         r[base + 4'd3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return r;
   endfunction

   // t is SubWord(RotWord(w3)) ^ rcon, already formed upstream.
   function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [31:0] t);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ t;
      w1 = k[95:64]  ^ w0;
      w2 = k[63:32]  ^ w1;
      w3 = k[31:0]   ^ w2;
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_round_pipe_if.sv
// Valid/ready block bus used on both sides of aes_round_pipe.
//   valid/ready : handshake, transfer when both are high
//   state, key  : 128-bit round state and round key
//   num         : round number
//   tag         : opaque sideband, TAG_W bits
//   err         : illegal-round flag (meaningful on the result side only)
// master drives the payload, slave drives ready.
interface aes_round_pipe_if
   import aes_pkg::*;
#(
   parameter int unsigned TAG_W = 8
);

   logic             valid;
   logic             ready;
   aes_state_t       state;
   aes_state_t       key;
   logic [3:0]       num;
   logic [TAG_W-1:0] tag;
   logic             err;

   modport master (output valid, state, key, num, tag, err, input ready);
   modport slave  (input valid, state, key, num, tag, err, output ready);

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES byte substitution.
//   x : input byte
//   y : substituted byte
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] x,
   output logic [7:0] y
);

   assign y = sbox(x);

endmodule

// File: rtl/aes_round_pipe.sv
// One AES-128 encryption round with on-the-fly key expansion in an elastic
// valid/ready pipeline of STAGES (1..4) register stages.
//   clk   : clock, rising edge
//   rst   : asynchronous reset, active low
//   flush : synchronous drop of every in-flight block
//   up    : input blocks (state, previous round key, num, tag); err unused
//   dn    : results (state, round key k(num), num, tag, err)
// Logical steps: SubBytes+SubWord, ShiftRows+key chain, MixColumns,
// AddRoundKey. Fewer stages drop the leading step boundaries.
module aes_round_pipe
   import aes_pkg::*;
#(
   parameter int unsigned STAGES = 4,
   parameter int unsigned TAG_W  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   aes_round_pipe_if.slave  up,
   aes_round_pipe_if.master dn
);

   // Lowest step boundary that carries a register; boundaries 1..4 follow
   // steps 1..4, and the last STAGES of them are registered.
   localparam int unsigned FIRST = 5 - STAGES;

   typedef struct packed {
      aes_state_t       st;
      logic [127:0]     key;
      logic [31:0]      tmp;
      logic [3:0]       num;
      logic [TAG_W-1:0] tag;
      logic             err;
   } pipe_t;

   // Illegal blocks pass state and key through every step untouched.
   function automatic pipe_t do_shift(input pipe_t p);
      pipe_t r;
      r     = p;
      r.tmp = '0;
      if (!p.err) begin
         r.st  = shift_rows(p.st);
         r.key = expand_key(p.key, p.tmp);
      end
      return r;
   endfunction

   function automatic pipe_t do_mix(input pipe_t p);
      pipe_t r;
      r = p;
      if (!p.err && (p.num != AES_LAST_ROUND)) r.st = mix_columns(p.st);
      return r;
   endfunction

   function automatic pipe_t do_ark(input pipe_t p);
      pipe_t r;
      r = p;
      if (!p.err) r.st = p.st ^ p.key;
      return r;
   endfunction

   aes_state_t      sub_st;
   logic [0:3][7:0] sub_w;
   logic            illegal;
   pipe_t           s1, s2, s3, s4;
   pipe_t           i2, i3, i4;
   pipe_t           step [1:4];

   logic [STAGES-1:0] vld_q;
   logic [STAGES:0]   rdy;
   pipe_t             stage_q [STAGES];

   // Step 1: SubBytes on the state and SubWord(RotWord(w3)) on the key.
   for (genvar i = 0; i < 16; i++) begin : g_sb_state
      aes_sbox u_sbox (.x(up.state[i]), .y(sub_st[i]));
   end

   for (genvar j = 0; j < 4; j++) begin : g_sb_word
      aes_sbox u_sbox (.x(up.key[12 + ((j + 1) % 4)]), .y(sub_w[j]));
   end

   assign illegal = (up.num == 4'd0) || (up.num > AES_LAST_ROUND);

   always_comb begin
      s1     = '0;
      s1.num = up.num;
      s1.tag = up.tag;
      s1.err = illegal;
      s1.key = up.key;
      s1.st  = illegal ? up.state : sub_st;
      s1.tmp = illegal ? '0 : (sub_w ^ {RCON[up.num], 24'h000000});
   end

   // Each later step reads either the register after the previous step or,
   // where that boundary is merged away, the previous step directly.
   if (FIRST <= 1) begin : g_b1_reg
      assign i2 = stage_q[1 - FIRST];
   end else begin : g_b1_comb
      assign i2 = s1;
   end

   if (FIRST <= 2) begin : g_b2_reg
      assign i3 = stage_q[2 - FIRST];
   end else begin : g_b2_comb
      assign i3 = s2;
   end

   if (FIRST <= 3) begin : g_b3_reg
      assign i4 = stage_q[3 - FIRST];
   end else begin : g_b3_comb
      assign i4 = s3;
   end

   assign s2   = do_shift(i2);
   assign s3   = do_mix(i3);
   assign s4   = do_ark(i4);
   assign step = '{s1, s2, s3, s4};

   // Elastic control: a stage accepts when empty or when its successor accepts.
   assign rdy[STAGES] = dn.ready;

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      logic  in_vld;
      pipe_t d_in;
      logic  v_r;
      pipe_t d_r;

      if (s == 0) begin : g_head
         assign in_vld = up.valid & ~flush;
      end else begin : g_body
         assign in_vld = vld_q[s - 1];
      end

      assign d_in   = step[FIRST + s];
      assign rdy[s] = ~v_r | rdy[s + 1];

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            v_r <= 1'b0;
            d_r <= '0;
         end else if (flush) begin
            v_r <= 1'b0;
         end else if (rdy[s]) begin
            v_r <= in_vld;
            if (in_vld) d_r <= d_in;
         end
      end

      assign vld_q[s]   = v_r;
      assign stage_q[s] = d_r;
   end

   assign up.ready = rdy[0] & ~flush;

   assign dn.valid = vld_q[STAGES - 1];
   assign dn.state = stage_q[STAGES - 1].st;
   assign dn.key   = stage_q[STAGES - 1].key;
   assign dn.num   = stage_q[STAGES - 1].num;
   assign dn.tag   = stage_q[STAGES - 1].tag;
   assign dn.err   = stage_q[STAGES - 1].err;

   logic unused_ok;
   assign unused_ok = ^{stage_q[STAGES - 1].tmp, up.err};

endmodule

// File: tb/tb_aes_round_pipe.sv
// Directed bench for aes_round_pipe at STAGES = 4, 1 and 3. One shared driver
// feeds whichever instance "sel" points at; the others see no input and an
// always-ready output. Expected values are FIPS-197 round vectors.
module tb_aes_round_pipe;

   localparam logic [127:0] R1_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
   localparam logic [127:0] K0      = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] R1_OUT  = 128'ha49c7ff2689f352b6b5bea43026a5049;
   localparam logic [127:0] K1      = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] R2_OUT  = 128'haa8f5f0361dde3ef82d24ad26832469a;
   localparam logic [127:0] K2      = 128'hf2c295f27a96b9435935807a7359f67f;
   localparam logic [127:0] R3_OUT  = 128'h486c4eee671d9d0d4de3b138d65f58e7;
   localparam logic [127:0] K3      = 128'h3d80477d4716fe3e1e237e446d7a883b;
   localparam logic [127:0] R10_IN  = 128'heb40f21e592e38848ba113e71bc342d2;
   localparam logic [127:0] K9      = 128'hac7766f319fadc2128d12941575c006e;
   localparam logic [127:0] R10_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] K10     = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] X_ST    = 128'h0123456789abcdeffedcba9876543210;
   localparam logic [127:0] X_KEY   = 128'h00112233445566778899aabbccddeeff;

   typedef struct {
      int unsigned  sel;
      logic [127:0] st;
      logic [127:0] key;
      logic [3:0]   num;
      logic [7:0]   tag;
      logic [127:0] exp_st;
      logic [127:0] exp_key;
      logic         exp_err;
   } vec_t;

   vec_t vecs [10];

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   int unsigned  sel;
   logic         drv_valid, drv_ready;
   logic [127:0] drv_state, drv_key;
   logic [3:0]   drv_num;
   logic [7:0]   drv_tag;

   logic         m_rdy, m_vld, m_err;
   logic [127:0] m_st, m_key;
   logic [3:0]   m_num;
   logic [7:0]   m_tag;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   aes_round_pipe_if #(.TAG_W(8)) up4 ();
   aes_round_pipe_if #(.TAG_W(8)) dn4 ();
   aes_round_pipe_if #(.TAG_W(8)) up1 ();
   aes_round_pipe_if #(.TAG_W(8)) dn1 ();
   aes_round_pipe_if #(.TAG_W(8)) up3 ();
   aes_round_pipe_if #(.TAG_W(8)) dn3 ();

   assign up4.valid = drv_valid & (sel == 0);
   assign up1.valid = drv_valid & (sel == 1);
   assign up3.valid = drv_valid & (sel == 2);
   assign up4.state = drv_state;  assign up1.state = drv_state;  assign up3.state = drv_state;
   assign up4.key   = drv_key;    assign up1.key   = drv_key;    assign up3.key   = drv_key;
   assign up4.num   = drv_num;    assign up1.num   = drv_num;    assign up3.num   = drv_num;
   assign up4.tag   = drv_tag;    assign up1.tag   = drv_tag;    assign up3.tag   = drv_tag;
   assign up4.err   = 1'b0;       assign up1.err   = 1'b0;       assign up3.err   = 1'b0;
   assign dn4.ready = (sel == 0) ? drv_ready : 1'b1;
   assign dn1.ready = (sel == 1) ? drv_ready : 1'b1;
   assign dn3.ready = (sel == 2) ? drv_ready : 1'b1;

   aes_round_pipe #(.STAGES(4), .TAG_W(8)) u_s4 (
      .clk(clk), .rst(rst_n), .flush(flush), .up(up4.slave), .dn(dn4.master));
   aes_round_pipe #(.STAGES(1), .TAG_W(8)) u_s1 (
      .clk(clk), .rst(rst_n), .flush(flush), .up(up1.slave), .dn(dn1.master));
   aes_round_pipe #(.STAGES(3), .TAG_W(8)) u_s3 (
      .clk(clk), .rst(rst_n), .flush(flush), .up(up3.slave), .dn(dn3.master));

   always_comb begin
      m_rdy = up4.ready; m_vld = dn4.valid; m_st = dn4.state; m_key = dn4.key;
      m_num = dn4.num;   m_tag = dn4.tag;   m_err = dn4.err;
      if (sel == 1) begin
         m_rdy = up1.ready; m_vld = dn1.valid; m_st = dn1.state; m_key = dn1.key;
         m_num = dn1.num;   m_tag = dn1.tag;   m_err = dn1.err;
      end else if (sel == 2) begin
         m_rdy = up3.ready; m_vld = dn3.valid; m_st = dn3.state; m_key = dn3.key;
         m_num = dn3.num;   m_tag = dn3.tag;   m_err = dn3.err;
      end
   end

   function automatic int unsigned lat_of(input int unsigned s);
      return (s == 1) ? 1 : (s == 2) ? 3 : 4;
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int unsigned lat;
      logic        got;
      @(negedge clk);
      sel = v.sel; drv_state = v.st; drv_key = v.key; drv_num = v.num; drv_tag = v.tag;
      drv_ready = 1'b1; drv_valid = 1'b1;
      #1;
      chk($sformatf("v%0d in_ready", idx), m_rdy, 1);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 12) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         drv_valid = 1'b0;
         #1;
         got = m_vld;
      end
      chk($sformatf("v%0d latency", idx), lat, lat_of(v.sel));
      chk($sformatf("v%0d state", idx), m_st, v.exp_st);
      chk($sformatf("v%0d key", idx), m_key, v.exp_key);
      chk($sformatf("v%0d num", idx), m_num, v.num);
      chk($sformatf("v%0d tag", idx), m_tag, v.tag);
      chk($sformatf("v%0d err", idx), m_err, v.exp_err);
      @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d single", idx), m_vld, 0);
   endtask

   // Loads four round-1 blocks into the STAGES=4 instance with output stalled.
   task automatic fill_s4();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         sel = 0; drv_ready = 1'b0; drv_valid = 1'b1;
         drv_state = R1_IN; drv_key = K0; drv_num = 4'd1; drv_tag = 8'(8'h40 + i);
      end
      @(negedge clk);
      drv_valid = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; sel = 0;
      drv_valid = 1'b0; drv_ready = 1'b1;
      drv_state = '0; drv_key = '0; drv_num = '0; drv_tag = '0;

      vecs[0] = '{0, R1_IN,  K0,    4'd1,  8'ha0, R1_OUT,  K1,    1'b0};
      vecs[1] = '{1, R10_IN, K9,    4'd10, 8'ha1, R10_OUT, K10,   1'b0};
      vecs[2] = '{2, R1_OUT, K1,    4'd2,  8'ha2, R2_OUT,  K2,    1'b0};
      vecs[3] = '{0, X_ST,   X_KEY, 4'd0,  8'ha3, X_ST,    X_KEY, 1'b1};
      vecs[4] = '{2, X_KEY,  X_ST,  4'd12, 8'ha4, X_KEY,   X_ST,  1'b1};
      vecs[5] = '{1, X_ST,   X_KEY, 4'd15, 8'ha5, X_ST,    X_KEY, 1'b1};
      vecs[6] = '{1, R1_IN,  K0,    4'd1,  8'ha6, R1_OUT,  K1,    1'b0};
      vecs[7] = '{0, R10_IN, K9,    4'd10, 8'ha7, R10_OUT, K10,   1'b0};
      vecs[8] = '{2, R2_OUT, K2,    4'd3,  8'ha8, R3_OUT,  K3,    1'b0};
      vecs[9] = '{0, X_KEY,  X_ST,  4'd11, 8'ha9, X_KEY,   X_ST,  1'b1};

      #1;
      chk("reset out_valid", m_vld, 0);
      chk("reset state_out", m_st, 0);
      chk("reset key_out", m_key, 0);
      chk("reset tag_out", m_tag, 0);
      chk("reset err_out", m_err, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("reset in_ready", m_rdy, 1);

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Backpressure on STAGES=3: even tags are round 1, odd tags round 2.
      begin
         int unsigned nin, nout;
         logic        held;
         logic [7:0]  h_tag;
         logic [127:0] h_st;
         nin = 0; nout = 0; held = 1'b0; h_tag = '0; h_st = '0;
         for (int cyc = 0; cyc < 200 && nout < 10; cyc++) begin
            @(negedge clk);
            sel       = 2;
            drv_ready = (cyc >= 6) && (((cyc - 6) % 5) < 2);
            drv_valid = (nin < 10);
            drv_tag   = 8'(nin);
            drv_state = nin[0] ? R1_OUT : R1_IN;
            drv_key   = nin[0] ? K1 : K0;
            drv_num   = nin[0] ? 4'd2 : 4'd1;
            #1;
            if (cyc == 5) begin
               chk("bp fill count", nin, 3);
               chk("bp in_ready full", m_rdy, 0);
            end
            if (held) begin
               chk("bp hold valid", m_vld, 1);
               chk("bp hold tag", m_tag, h_tag);
               chk("bp hold state", m_st, h_st);
            end
            if (m_vld && drv_ready) begin
               chk($sformatf("bp order tag%0d", nout), m_tag, nout);
               chk($sformatf("bp state tag%0d", nout), m_st, (nout % 2 == 1) ? R2_OUT : R1_OUT);
               nout++;
            end
            held  = m_vld && !drv_ready;
            h_tag = m_tag;
            h_st  = m_st;
            if (drv_valid && m_rdy) nin++;
         end
         chk("bp all delivered", nout, 10);
         @(negedge clk);
         drv_valid = 1'b0;
         drv_ready = 1'b1;
      end

      // Flush with four blocks in flight on STAGES=4.
      begin
         int unsigned ghosts;
         fill_s4();
         flush = 1'b1; drv_ready = 1'b1; drv_valid = 1'b1; drv_tag = 8'h55;
         #1;
         chk("flush pipe full", m_vld, 1);
         chk("flush in_ready", m_rdy, 0);
         @(negedge clk);
         flush = 1'b0; drv_valid = 1'b0;
         #1;
         chk("flush clears", m_vld, 0);
         ghosts = 0;
         for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (m_vld) ghosts++;
         end
         chk("flush no ghost", ghosts, 0);
         run_vec(vecs[0], 20);
      end

      // Asynchronous reset between edges with a held block.
      fill_s4();
      #1;
      chk("rst pre valid", m_vld, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst async valid", m_vld, 0);
      chk("rst async state", m_st, 0);
      chk("rst async key", m_key, 0);
      chk("rst async tag", m_tag, 0);
      @(negedge clk);
      rst_n = 1'b1; drv_ready = 1'b1;
      #1;
      chk("rst release in_ready", m_rdy, 1);
      run_vec(vecs[0], 30);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule
